// File: rtl/pattern_gen_pipe_pkg.sv
// pattern_pkg: mode encodings and cfg field positions for pattern_gen_pipe
package pattern_pkg;
   localparam logic [2:0] MODE_PASS  = 3'd0;
   localparam logic [2:0] MODE_RAMP  = 3'd1;
   localparam logic [2:0] MODE_BARS  = 3'd2;
   localparam logic [2:0] MODE_XORS  = 3'd3;
   localparam logic [2:0] MODE_CHECK = 3'd4;
   localparam int CFG_PRI_LSB  = 0;
   localparam int CFG_DIV_LSB  = 2;
   localparam int CFG_MODE_LSB = 4;
endpackage

// File: rtl/pattern_gen_pipe_delay_line.sv
// delay_line: DEPTH-stage register chain with synchronous clear
module delay_line #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);
   logic [WIDTH-1:0] s [DEPTH];
   always_ff @(posedge clk)
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) s[i] <= '0;
      end else begin
         s[0] <= d;
         for (int i = 1; i < DEPTH; i++) s[i] <= s[i-1];
      end
   assign q = s[DEPTH-1];
endmodule

// File: rtl/pattern_gen_pipe.sv
// pattern_gen_pipe: test-pattern generator with frame-synchronous reconfiguration and aligned output pipeline
module pattern_gen_pipe
   import pattern_pkg::*;
#(
   parameter int BITS      = 8,
   parameter int HBITS     = 10,
   parameter int PIPE      = 2,
   parameter int BAR_SHIFT = 6
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [7:0]       cfg_in,
   input  logic             cfg_load,
   output logic             cfg_busy,
   input  logic [HBITS-1:0] h,
   input  logic [HBITS-1:0] v,
   input  logic             visible_in,
   input  logic             hsync_in,
   input  logic             vsync_in,
   input  logic             hblank_in,
   input  logic             vblank_in,
   input  logic             frame_end,
   input  logic [BITS-1:0]  pass_in,
   output logic [BITS-1:0]  r,
   output logic [BITS-1:0]  g,
   output logic [BITS-1:0]  b,
   output logic             hsync,
   output logic             vsync,
   output logic             hblank,
   output logic             vblank,
   output logic [7:0]       frame_count
);
   logic [6:0] cfg_act, pending;
   logic unused_cfg;
   assign unused_cfg = cfg_in[7];
   always_ff @(posedge clk)
      if (reset) begin
         cfg_act     <= cfg_in[6:0];
         pending     <= '0;
         cfg_busy    <= 1'b0;
         frame_count <= '0;
      end else begin
         frame_count <= frame_count + {7'd0, frame_end};
         // a busy flag at frame_end wins, so a load in that same cycle is only captured when idle
         if (frame_end && cfg_busy) begin
            cfg_act  <= pending;
            cfg_busy <= 1'b0;
         end else if (cfg_load && !cfg_busy) begin
            pending  <= cfg_in[6:0];
            cfg_busy <= 1'b1;
         end
      end
   logic [2:0]        mode, idx;
   logic [1:0]        div, pri;
   logic [BITS-1:0]   rampa, rampb, rampc;
   logic              chk;
   logic [3*BITS-1:0] rgb, pix, q_rgb;
   assign mode  = cfg_act[CFG_MODE_LSB +: 3];
   assign div   = cfg_act[CFG_DIV_LSB +: 2];
   assign pri   = cfg_act[CFG_PRI_LSB +: 2];
   assign rampa = BITS'(h >> div);
   assign rampb = BITS'(v);
   assign rampc = BITS'({frame_count, BITS'(0)} >> 8);
   assign idx   = 3'(h >> (BAR_SHIFT + div));
   assign chk   = 1'((h ^ v) >> (3 + div)) ^ frame_count[5];
   always_comb begin
      rgb = '0;
      case (mode)
         MODE_PASS:  rgb = {3{pass_in}};
         MODE_RAMP:  rgb = pri == 2'd0 ? {rampa, rampb, rampc} :
                           pri == 2'd1 ? {rampc, rampa, rampb} :
                           pri == 2'd2 ? {rampb, rampc, rampa} : {3{rampa}};
         MODE_BARS:  rgb = {{BITS{~idx[1]}}, {BITS{~idx[2]}}, {BITS{~idx[0]}}};
         MODE_XORS:  rgb = {BITS'(h ^ v), BITS'(h & v), BITS'(h - v) + rampc};
         MODE_CHECK: rgb = {(3*BITS){chk}};
         default:    rgb = '0;
      endcase
   end
   assign pix = visible_in ? rgb : '0;
   delay_line #(.WIDTH(3*BITS + 4), .DEPTH(PIPE)) u_dly (
      .clk   (clk),
      .reset (reset),
      .d     ({pix, hsync_in, vsync_in, hblank_in, vblank_in}),
      .q     ({q_rgb, hsync, vsync, hblank, vblank})
   );
   assign {r, g, b} = q_rgb;
endmodule
